// File: rtl/seq_fx_multiplier.sv
// Iterative radix-2 shift-add multiplier: signed/unsigned per operation, fixed-point result
// extraction (fx_final, since "final" is reserved) with overflow flag. Optional macro: SATURATE_EN.
module seq_fx_multiplier #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   fx_final,
    output logic               overflow
);

    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int SHIFT_S = FRAC_BITS + WIDTH - 1;
    localparam int SHIFT_U = FRAC_BITS + WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     counter;
    logic [2*WIDTH-1:0]   mcand_sh;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 sign_q;
    logic                 signed_q;

    logic                 accept;
    logic                 last_bit;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   res_product;
    logic [2*WIDTH-1:0]   hi_signed;
    logic [2*WIDTH-1:0]   hi_unsigned;
    logic [WIDTH-1:0]     res_final;
    logic                 res_ovf;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (counter == CNT_W'(WIDTH - 1));

    // Magnitudes: the most negative value maps onto itself, which is correct read as unsigned.
    assign mag_a = (is_signed && multicand[WIDTH-1])  ? -multicand  : multicand;
    assign mag_b = (is_signed && multiplier[WIDTH-1]) ? -multiplier : multiplier;

    // NOTE: the state register uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = BUSY;
            BUSY:    if (last_bit) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result path: the final partial sum is sign-corrected and sliced before it is registered.
    always_comb begin
        acc_next    = acc + (mplier[0] ? mcand_sh : '0);
        res_product = sign_q ? -acc_next : acc_next;
        hi_signed   = $signed(res_product) >>> SHIFT_S;
        hi_unsigned = res_product >> SHIFT_U;
        res_ovf     = signed_q ? !((hi_signed == '0) || (hi_signed == '1))
                               : (hi_unsigned != '0);
        res_final   = res_product[FRAC_BITS +: WIDTH];
`ifdef SATURATE_EN
        if (res_ovf) begin
            if (!signed_q) begin
                res_final = '1;
            end else if (res_product[2*WIDTH-1]) begin
                res_final = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res_final = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign_q   <= 1'b0;
            signed_q <= 1'b0;
            product  <= '0;
            fx_final <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand_sh <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        acc      <= '0;
                        counter  <= '0;
                        sign_q   <= is_signed & (multicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        signed_q <= is_signed;
                    end
                end
                BUSY: begin
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    counter  <= counter + 1'b1;
                    if (last_bit) begin
                        product  <= res_product;
                        fx_final <= res_final;
                        overflow <= res_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fx_multiplier.sv
// Self-checking bench for seq_fx_multiplier: directed cases plus a randomized
// back-to-back run against an arithmetic reference model (Q32.0 and Q16.16 instances).
module tb_seq_fx_multiplier;

    localparam int W = 32;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           is_signed;
    logic [W-1:0]   multicand;
    logic [W-1:0]   multiplier;
    logic           out_ready;

    logic           in_ready, out_valid, overflow;
    logic [2*W-1:0] product;
    logic [W-1:0]   fx_final;
    logic           q_in_ready, q_out_valid, q_overflow;
    logic [2*W-1:0] q_product;
    logic [W-1:0]   q_fx_final;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_fx_multiplier #(.WIDTH(W), .FRAC_BITS(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .multicand(multicand), .multiplier(multiplier),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .fx_final(fx_final), .overflow(overflow)
    );

    seq_fx_multiplier #(.WIDTH(W), .FRAC_BITS(16)) dut_q (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(q_in_ready),
        .is_signed(is_signed), .multicand(multicand), .multiplier(multiplier),
        .out_valid(q_out_valid), .out_ready(out_ready), .product(q_product),
        .fx_final(q_fx_final), .overflow(q_overflow)
    );

    // Reference model: exact integer product, then range check of floor(product / 2^frac).
    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic model_ovf(input logic [63:0] p, input logic s, input int frac);
        longint     q;
        logic [63:0] uq;
        if (s) begin
            q = $signed(p) >>> frac;
            return (q < SMIN) || (q > SMAX);
        end
        uq = p >> frac;
        return uq > 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [31:0] model_final(input logic [63:0] p, input logic s, input int frac);
        logic [63:0] sh;
        sh = p >> frac;
        if (SAT && model_ovf(p, s, frac)) begin
            if (!s) return 32'hFFFF_FFFF;
            return p[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return sh[31:0];
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        multicand  = a;
        multiplier = b;
        is_signed  = s;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (!out_valid) $display("FAIL wait_valid: out_valid=%0b after %0d edges, required 1", out_valid, edges);
        else n_pass++;
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, overflow} !== 3'b100) $display("FAIL reset_flags: got %b, required 100", {in_ready, out_valid, overflow});
        else n_pass++;
        n_checks++;
        if (product !== 64'd0 || fx_final !== 32'd0) $display("FAIL reset_data: product=%h final=%h, required 0", product, fx_final);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_overflow();
        int lat;
        start_op(32'h1000_0010, 32'h0000_0010, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL busy_in_ready: got %b, required 0", in_ready);
        else n_pass++;
        wait_valid(lat);
        n_checks++;
        if (lat !== 32) $display("FAIL latency: got %0d edges, required 32", lat);
        else n_pass++;
        n_checks++;
        if (product !== 64'h0000_0001_0000_0100) $display("FAIL u_product: got %h, required 0000000100000100", product);
        else n_pass++;
        n_checks++;
        if (fx_final !== (SAT ? 32'hFFFF_FFFF : 32'h0000_0100)) $display("FAIL u_final: got %h", fx_final);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL u_overflow: got %b, required 1", overflow);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_signed();
        int lat;
        start_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        wait_valid(lat);
        n_checks++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFF1 || fx_final !== 32'hFFFF_FFF1 || overflow !== 1'b0)
            $display("FAIL s_neg3x5: got %h/%h/%b, required FFFFFFFFFFFFFFF1/FFFFFFF1/0", product, fx_final, overflow);
        else n_pass++;
        n_checks++;
        if (q_fx_final !== 32'hFFFF_FFFF || q_overflow !== 1'b0)
            $display("FAIL q_neg3x5: got %h/%b, required FFFFFFFF/0", q_fx_final, q_overflow);
        else n_pass++;
        finish_op();
        start_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
        wait_valid(lat);
        n_checks++;
        if (product !== 64'h0000_0004_FFFF_FFF1 || overflow !== 1'b1)
            $display("FAIL u_fffffffdx5: got %h/%b, required 00000004FFFFFFF1/1", product, overflow);
        else n_pass++;
        n_checks++;
        if (fx_final !== (SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFF1)) $display("FAIL u_fffffffdx5_final: got %h", fx_final);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_fixed_point();
        int lat;
        start_op(32'h0001_8000, 32'h0002_0000, 1'b1);
        wait_valid(lat);
        n_checks++;
        if (q_fx_final !== 32'h0003_0000 || q_overflow !== 1'b0)
            $display("FAIL q16_1p5x2: got %h/%b, required 00030000/0", q_fx_final, q_overflow);
        else n_pass++;
        finish_op();
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_valid(lat);
        n_checks++;
        if (q_product !== 64'h4000_0000_0000_0000 || q_overflow !== 1'b1)
            $display("FAIL q16_minxmin: got %h/%b, required 4000000000000000/1", q_product, q_overflow);
        else n_pass++;
        n_checks++;
        if (q_fx_final !== (SAT ? 32'h7FFF_FFFF : 32'h0000_0000)) $display("FAIL q16_minxmin_final: got %h", q_fx_final);
        else n_pass++;
        n_checks++;
        if (product !== 64'h4000_0000_0000_0000 || overflow !== 1'b1)
            $display("FAIL q0_minxmin: got %h/%b, required 4000000000000000/1", product, overflow);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_zero_operand();
        int lat;
        start_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_valid(lat);
        n_checks++;
        if (lat !== 32 || product !== 64'd0 || overflow !== 1'b0)
            $display("FAIL zero_operand: got lat=%0d product=%h ovf=%b, required 32/0/0", lat, product, overflow);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_backpressure();
        int          lat;
        logic        stable;
        logic [63:0] held_p;
        logic [31:0] held_f;
        logic        held_o;
        start_op(32'h0000_1234, 32'h0000_0100, 1'b0);
        wait_valid(lat);
        held_p = product;
        held_f = fx_final;
        held_o = overflow;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            multicand  = $urandom;
            multiplier = $urandom;
            if (!out_valid || in_ready || product !== held_p || fx_final !== held_f || overflow !== held_o)
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) $display("FAIL backpressure_hold: stable=%b, required 1", stable);
        else n_pass++;
        n_checks++;
        if (held_p !== 64'h0000_0000_0012_3400) $display("FAIL backpressure_product: got %h, required 0000000000123400", held_p);
        else n_pass++;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL no_stray_accept: in_ready=%b, required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat;
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'd0 || fx_final !== 32'd0 || overflow !== 1'b0)
            $display("FAIL abort: ov=%b ir=%b product=%h final=%h ovf=%b, required 0/1/0/0/0", out_valid, in_ready, product, fx_final, overflow);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        start_op(32'd7, 32'd6, 1'b0);
        wait_valid(lat);
        n_checks++;
        if (product !== 64'd42 || fx_final !== 32'd42 || overflow !== 1'b0)
            $display("FAIL after_abort: got %h/%h/%b, required 42/42/0", product, fx_final, overflow);
        else n_pass++;
        finish_op();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic        qs[$];
        logic [31:0] a, b;
        logic        s;
        logic [63:0] ep;
        int          sent, got, cyc, bad;
        sent = 0;
        got  = 0;
        cyc  = 0;
        bad  = 0;
        while (got < 20 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    $display("FAIL b2b_extra_result: product=%h with no pending accept", product);
                    bad++;
                end else begin
                    a  = qa.pop_front();
                    b  = qb.pop_front();
                    s  = qs.pop_front();
                    ep = model_prod(a, b, s);
                    n_checks++;
                    if (product !== ep || fx_final !== model_final(ep, s, 0) || overflow !== model_ovf(ep, s, 0))
                        $display("FAIL b2b_q0 #%0d: %h*%h s=%b got %h/%h/%b, required %h/%h/%b", got, a, b, s,
                                 product, fx_final, overflow, ep, model_final(ep, s, 0), model_ovf(ep, s, 0));
                    else n_pass++;
                    n_checks++;
                    if (q_product !== ep || q_fx_final !== model_final(ep, s, 16) || q_overflow !== model_ovf(ep, s, 16))
                        $display("FAIL b2b_q16 #%0d: %h*%h s=%b got %h/%h/%b, required %h/%h/%b", got, a, b, s,
                                 q_product, q_fx_final, q_overflow, ep, model_final(ep, s, 16), model_ovf(ep, s, 16));
                    else n_pass++;
                    got++;
                end
            end
            if (sent < 20) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                multicand  = rand_operand();
                multiplier = rand_operand();
                is_signed  = 1'($urandom_range(0, 1));
                if (in_valid && in_ready) begin
                    qa.push_back(multicand);
                    qb.push_back(multiplier);
                    qs.push_back(is_signed);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        n_checks++;
        if (got != 20 || qa.size() != 0 || bad != 0)
            $display("FAIL b2b_count: got %0d results, %0d pending, %0d extra; required 20/0/0", got, qa.size(), bad);
        else n_pass++;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        is_signed  = 1'b0;
        multicand  = '0;
        multiplier = '0;
        out_ready  = 1'b0;
        test_reset();
        test_unsigned_overflow();
        test_signed();
        test_fixed_point();
        test_zero_operand();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
